// File: rtl/sum_accumulator.sv
// sum_accumulator: first clocked stage after the 4-bit adder.
// Accepts COUNT {c,o} results over valid/ready, sums them modulo 2^ACC_W with a
// sticky wrap flag, then holds the frame total until downstream takes it.
module sum_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_c,
    input  logic [3:0]       in_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    // Counter must hold 0..COUNT-1 at least; keep it at one bit minimum.
    localparam int CNT_W = ($clog2(COUNT + 1) < 1) ? 1 : $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    logic               accept;
    logic [ACC_W:0]     sample_w;
    logic [ACC_W:0]     sum_w;

    // Handshake flags are pure state decodes, so no input reaches them combinationally.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    assign accept   = in_valid && in_ready;
    // One extra bit above the accumulator captures the carry out of bit ACC_W-1.
    assign sample_w = {{(ACC_W - 4){1'b0}}, in_c, in_o};
    assign sum_w    = {1'b0, acc_q} + sample_w;

    // Next-state: clear wins over everything, then the per-state handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = sum_w[ACC_W-1:0];
                        ovf_d = ovf_q | sum_w[ACC_W];
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Total taken: restart the frame; no sample is accepted this edge.
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State registers; reset drops any partial frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: two instances (ACC_W=8 and ACC_W=6, COUNT=4)
// share one stimulus stream; a frame-total model predicts both.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_c = 1'b0;
    logic [3:0] in_o = 4'd0;
    logic       out_ready = 1'b0;

    logic       rdy8, vld8, ovf8;
    logic [7:0] sum8;
    logic       rdy6, vld6, ovf6;
    logic [5:0] sum6;

    int tests = 0;
    int fails = 0;
    // Model: plain integer total of accepted samples and how many were accepted.
    int tot  = 0;
    int nacc = 0;

    sum_accumulator #(.COUNT(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy8),
        .in_c(in_c), .in_o(in_o), .out_valid(vld8), .out_ready(out_ready),
        .out_sum(sum8), .out_ovf(ovf8)
    );

    sum_accumulator #(.COUNT(4), .ACC_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy6),
        .in_c(in_c), .in_o(in_o), .out_valid(vld6), .out_ready(out_ready),
        .out_sum(sum6), .out_ovf(ovf6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare visible totals against the model for both widths.
    task automatic chk_run(input string tag);
        chk({tag, " sum8"}, 32'(sum8), 32'(tot % 256));
        chk({tag, " ovf8"}, 32'(ovf8), 32'(tot >= 256));
        chk({tag, " sum6"}, 32'(sum6), 32'(tot % 64));
        chk({tag, " ovf6"}, 32'(ovf6), 32'(tot >= 64));
    endtask

    task automatic chk_state(input string tag, input bit hold);
        chk({tag, " rdy8"}, 32'(rdy8), 32'(!hold));
        chk({tag, " vld8"}, 32'(vld8), 32'(hold));
        chk({tag, " rdy6"}, 32'(rdy6), 32'(!hold));
        chk({tag, " vld6"}, 32'(vld6), 32'(hold));
    endtask

    task automatic accept(input int s);
        in_valid = 1'b1;
        {in_c, in_o} = 5'(s);
        step();
        in_valid = 1'b0;
        tot += s;
        nacc++;
        chk_run("accept");
        chk_state("accept", nacc == 4);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            {in_c, in_o} = 5'd31;
            step();
            chk_run("idle");
            chk_state("idle", 1'b0);
        end
    endtask

    // Hold the total under backpressure with junk offered, then take it.
    task automatic take(input int hold_cycles);
        for (int i = 0; i < hold_cycles; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            {in_c, in_o} = 5'd7;
            step();
            chk_run("hold");
            chk_state("hold", 1'b1);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        {in_c, in_o} = 5'd7;
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        tot = 0;
        nacc = 0;
        chk_run("take");
        chk_state("take", 1'b0);
    endtask

    task automatic do_clear(input int s, input bit v);
        clear = 1'b1;
        in_valid = v;
        {in_c, in_o} = 5'(s);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        tot = 0;
        nacc = 0;
        chk_run("clear");
        chk_state("clear", 1'b0);
    endtask

    initial begin
        // Power-on reset.
        #2;
        chk_run("por");
        chk_state("por", 1'b0);
        #10 rst_n = 1'b1;

        // Async reset mid-frame, between edges.
        accept(3);
        accept(3);
        #2 rst_n = 1'b0;
        #1;
        tot = 0;
        nacc = 0;
        chk_run("async_rst");
        chk_state("async_rst", 1'b0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) accept(1);
        chk("post_rst sum8", 32'(sum8), 32'd4);
        take(0);

        // Basic frame, out_ready held high throughout.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) accept(15);
        chk("basic sum8", 32'(sum8), 32'd60);
        take(0);

        // Overflow: 31 x4 -> narrow instance runs 31,62,29,60 with wrap.
        for (int i = 0; i < 4; i++) accept(31);
        chk("ovf sum6", 32'(sum6), 32'd60);
        chk("ovf ovf6", 32'(ovf6), 32'd1);
        take(0);
        for (int i = 0; i < 4; i++) accept(1);
        chk("ovf_next ovf6", 32'(ovf6), 32'd0);
        take(0);

        // Backpressure: 5 HOLD cycles with samples offered.
        for (int i = 0; i < 4; i++) accept(15);
        take(5);
        accept(2);

        // Finish that frame, then a gapped frame.
        accept(2); accept(2); accept(2);
        take(1);
        accept(1); idle(1); accept(2); idle(2); accept(3); accept(4);
        chk("gapped sum8", 32'(sum8), 32'd10);
        take(0);

        // Clear with a simultaneous sample, then a clean frame.
        accept(5); accept(6);
        do_clear(9, 1'b1);
        for (int i = 0; i < 4; i++) accept(2);
        chk("clear sum8", 32'(sum8), 32'd8);
        take(0);

        // Clear in HOLD discards the total.
        for (int i = 0; i < 4; i++) accept(2);
        do_clear(0, 1'b0);

        // Random frames with gaps, backpressure and occasional aborts.
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 4; k++) begin
                idle(int'($urandom_range(0, 2)));
                accept(int'($urandom_range(0, 31)));
                if (k < 3 && $urandom_range(0, 19) == 0) begin
                    do_clear(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                    break;
                end
            end
            if (nacc == 4) take(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
